// File: rtl/demux_sched.sv
// Scheduler steering one valid/ready stream into four 1-deep output channels.
// Define DEMUX_SKIP_EN for work-conserving round-robin that skips busy channels.
module demux_sched #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          mode,
    input  logic [1:0]    dest,
    output logic [1:0]    sel,
    output logic [3:0]    out_valid,
    input  logic [3:0]    out_ready,
    output logic [4*DW-1:0] out_data
);

    logic [1:0] ptr;
    logic [1:0] tgt;
    logic [3:0] free;
    logic       accept;

    // A channel can take a word if it is empty or is being drained this cycle.
    assign free = ~out_valid | out_ready;

`ifdef DEMUX_SKIP_EN
    logic [1:0] skip_tgt;
    logic [1:0] idx;

    // Scan from the farthest offset back to ptr so the nearest free channel wins.
    always_comb begin
        skip_tgt = ptr;
        idx      = ptr;
        for (int unsigned k = 0; k < 4; k++) begin
            idx = ptr + 2'(3 - k);
            if (free[idx]) skip_tgt = idx;
        end
    end

    assign tgt      = mode ? dest : skip_tgt;
    assign in_ready = mode ? free[dest] : |free;
`else
    assign tgt      = mode ? dest : ptr;
    assign in_ready = free[tgt];
`endif

    assign sel    = tgt;
    assign accept = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= '0;
            out_data  <= '0;
            ptr       <= '0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (accept && tgt == 2'(i)) begin
                    out_data[i*DW +: DW] <= in_data;
                    out_valid[i]         <= 1'b1;
                end else if (out_ready[i]) begin
                    out_valid[i] <= 1'b0;
                end
            end
            // In strict mode tgt equals ptr, so tgt+1 serves both variants.
            if (accept && !mode) ptr <= tgt + 2'd1;
        end
    end

endmodule

// File: tb/tb_demux_sched.sv
// Directed self-checking bench for demux_sched; also covers the DEMUX_SKIP_EN build.
module tb_demux_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        mode;
    logic [1:0]  dest;
    logic [1:0]  sel;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    demux_sched #(.DW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .mode      (mode),
        .dest      (dest),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] chd(input int c);
        return out_data[c*8 +: 8];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one word, expect it accepted toward channel ch and visible one cycle later.
    task automatic send(input logic [7:0] d, input logic [1:0] ch, input string tag);
        in_valid = 1'b1;
        in_data  = d;
        #1;
        check({tag, ".sel"}, 32'(sel), 32'(ch));
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        step();
        check({tag, ".valid"}, 32'(out_valid[ch]), 32'd1);
        check({tag, ".data"}, 32'(chd(int'(ch))), 32'(d));
    endtask

    logic [7:0] t2_words [5];

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        mode      = 1'b0;
        dest      = '0;
        out_ready = '0;
        t2_words  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

        // T1 reset
        step();
        step();
        rst = 1'b0;
        #1;
        check("t1.out_valid", 32'(out_valid), 32'h0);
        check("t1.out_data", out_data, 32'h0);
        check("t1.sel", 32'(sel), 32'd0);
        check("t1.in_ready", 32'(in_ready), 32'd1);

        // T2 round-robin with all consumers ready
        out_ready = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            send(t2_words[i], 2'(i % 4), $sformatf("t2.w%0d", i));
            check($sformatf("t2.onehot%0d", i), 32'(out_valid), 32'(4'b0001 << (i % 4)));
        end
        in_valid = 1'b0;
        step();
        check("t2.drained", 32'(out_valid), 32'h0);

        // T3 strict ordering with ch2 never drained
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 4'b1011;
        send(8'hA0, 2'd0, "t3.a0");
        send(8'hA1, 2'd1, "t3.a1");
        send(8'hA2, 2'd2, "t3.a2");
        check("t3.v_a2", 32'(out_valid), 32'b0100);
        send(8'hA3, 2'd3, "t3.a3");
        check("t3.v_a3", 32'(out_valid), 32'b1100);
        send(8'hA4, 2'd0, "t3.a4");
        check("t3.v_a4", 32'(out_valid), 32'b0101);
        send(8'hA5, 2'd1, "t3.a5");
        check("t3.v_a5", 32'(out_valid), 32'b0110);
`ifdef DEMUX_SKIP_EN
        in_valid = 1'b0;
        #1;
        check("t3.skip_sel", 32'(sel), 32'd3);
        check("t3.skip_rdy", 32'(in_ready), 32'd1);
        step();
        check("t3.hold_v", 32'(out_valid), 32'b0100);
        check("t3.hold_d", 32'(chd(2)), 32'hA2);
`else
        in_valid = 1'b1;
        in_data  = 8'hA6;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("t3.stall_sel%0d", c), 32'(sel), 32'd2);
            check($sformatf("t3.stall_rdy%0d", c), 32'(in_ready), 32'd0);
            step();
            check($sformatf("t3.stall_v%0d", c), 32'(out_valid), 32'b0100);
            check($sformatf("t3.stall_d%0d", c), 32'(chd(2)), 32'hA2);
        end
`endif
        out_ready = 4'b1111;
        send(8'hA6, 2'd2, "t3.a6");
        check("t3.v_a6", 32'(out_valid), 32'b0100);
        in_valid = 1'b0;
        step();
        check("t3.drained", 32'(out_valid), 32'h0);

        // T4 directed burst into ch2; ptr (3) must be untouched
        mode      = 1'b1;
        dest      = 2'd2;
        out_ready = 4'b0100;
        for (int i = 1; i <= 4; i++) begin
            send(8'(i), 2'd2, $sformatf("t4.w%0d", i));
            check($sformatf("t4.v%0d", i), 32'(out_valid), 32'b0100);
        end
        in_valid = 1'b0;
        mode     = 1'b0;
        #1;
        check("t4.ptr_kept", 32'(sel), 32'd3);
        step();

        // T5 hold on ch1, then reset mid-hold
        mode      = 1'b1;
        dest      = 2'd1;
        out_ready = 4'b0000;
        send(8'h5A, 2'd1, "t5.load");
        in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            check($sformatf("t5.hold_d%0d", c), 32'(chd(1)), 32'h5A);
            check($sformatf("t5.hold_v%0d", c), 32'(out_valid[1]), 32'd1);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5.rst_v", 32'(out_valid), 32'h0);
        check("t5.rst_d", out_data, 32'h0);

        // T6 ptr=1 with ch0/ch1 full and nobody draining
        mode = 1'b0;
        send(8'h60, 2'd0, "t6.w0");
        mode = 1'b1;
        dest = 2'd1;
        send(8'h61, 2'd1, "t6.w1");
        mode     = 1'b0;
        in_data  = 8'h62;
        in_valid = 1'b1;
        #1;
`ifdef DEMUX_SKIP_EN
        check("t6.sel", 32'(sel), 32'd2);
        check("t6.in_ready", 32'(in_ready), 32'd1);
        step();
        check("t6.v", 32'(out_valid), 32'b0111);
        check("t6.d2", 32'(chd(2)), 32'h62);
        in_valid = 1'b0;
        #1;
        check("t6.ptr", 32'(sel), 32'd3);
`else
        check("t6.sel", 32'(sel), 32'd1);
        check("t6.in_ready", 32'(in_ready), 32'd0);
        step();
        check("t6.v", 32'(out_valid), 32'b0011);
        check("t6.d2", 32'(chd(2)), 32'h00);
        check("t6.d1", 32'(chd(1)), 32'h61);
        in_valid = 1'b0;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
